// File: rtl/enc_pkg.sv
// Shared encoder definitions: sample width, macroblock geometry and the pixel type.
package enc_pkg;

  localparam int PIXEL_W   = 8;
  localparam int MB_DIM    = 16;
  localparam int MB_PIXELS = MB_DIM * MB_DIM;

  typedef logic [PIXEL_W-1:0] pixel_t;

endpackage : enc_pkg

// File: rtl/mb_sample_counter.sv
// Counts delivered samples within a macroblock, flags the last one and tallies
// completed macroblocks (16-bit, wrapping).
module mb_sample_counter
  import enc_pkg::*;
#(
  parameter int MB_PIXELS = enc_pkg::MB_PIXELS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        en,
  output logic        mb_last,
  output logic [15:0] mb_count
);

  localparam int CW = $clog2(MB_PIXELS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   mb_count_q, mb_count_d;

  assign mb_last  = en && (cnt_q == CW'(MB_PIXELS - 1));
  assign mb_count = mb_count_q;

  // NOTE: every variable gets its hold value first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d      = cnt_q;
    mb_count_d = mb_count_q;
    if (flush) begin
      cnt_d = '0;
    end else if (mb_last) begin
      cnt_d      = '0;
      mb_count_d = mb_count_q + 16'd1;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      mb_count_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      mb_count_q <= mb_count_d;
    end
  end

endmodule : mb_sample_counter

// File: rtl/mb_pixel_buffer.sv
// Elastic sample FIFO feeding the encoder's enabled pipeline register, with macroblock tagging.
// Optional occupancy port: define MB_PIXEL_BUFFER_LEVEL_EN.
module mb_pixel_buffer
  import enc_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DW        = PIXEL_W,
  parameter int MB_PIXELS = enc_pkg::MB_PIXELS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DW-1:0]           in_pixel,
  input  logic                    out_ready,
  output logic                    out_en,
  output logic [DW-1:0]           out_pixel,
  output logic                    mb_last,
  output logic [15:0]             mb_count
`ifdef MB_PIXEL_BUFFER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]  level
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          empty, full, push;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Ready depends only on registered pointers, keeping out_ready off the upstream path.
  assign in_ready  = ~full;
  assign push      = in_valid & ~full & ~flush;
  assign out_en    = ~empty & out_ready & ~flush;
  assign out_pixel = empty ? '0 : mem_q[rd_idx];

`ifdef MB_PIXEL_BUFFER_LEVEL_EN
  assign level = wr_ptr_q - rd_ptr_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (out_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty gates out_pixel, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= in_pixel;
  end

  mb_sample_counter #(
    .MB_PIXELS (MB_PIXELS)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .en       (out_en),
    .mb_last  (mb_last),
    .mb_count (mb_count)
  );

endmodule : mb_pixel_buffer
